// File: rtl/apb4_requester_if.sv
`default_nettype none
// ============================================================================
// Module   : apb4_requester_if
// Brief    : Command/response handshake and APB4 bus bundle for apb4_requester.
// Revision : 1.0 - initial release
// ============================================================================
interface apb4_requester_if #(
  parameter int ADDRWIDTH  = 8,
  parameter int DATAWIDTH  = 32,
  parameter int NUM_SLAVES = 4
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDRWIDTH-1:0]    cmd_addr;
  logic [DATAWIDTH-1:0]    cmd_wdata;
  logic [DATAWIDTH/8-1:0]  cmd_strb;
  logic [2:0]              cmd_prot;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATAWIDTH-1:0]    rsp_rdata;
  logic                    rsp_err;
  logic                    rsp_timeout;

  logic [ADDRWIDTH-1:0]    paddr;
  logic [NUM_SLAVES-1:0]   psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATAWIDTH-1:0]    pwdata;
  logic [DATAWIDTH/8-1:0]  pstrb;
  logic [2:0]              pprot;
  logic [DATAWIDTH-1:0]    prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot
  );
endinterface
`default_nettype wire

// File: rtl/apb4_requester.sv
`default_nettype none
// ============================================================================
// Module   : apb4_requester
// Brief    : Runs one APB4 transfer per accepted command, with address decode
//            error and ACCESS-phase timeout reporting on the response port.
// Revision : 1.0 - initial release
// ============================================================================
module apb4_requester #(
  parameter int ADDRWIDTH  = 8,
  parameter int DATAWIDTH  = 32,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  apb4_requester_if.master bus
);
  localparam int c_sel_bits = $clog2(NUM_SLAVES);
  localparam int c_strb_w   = DATAWIDTH / 8;
  localparam int c_wait_w   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_wait_w-1:0]   c_wait_last = (TIMEOUT > 0) ? c_wait_w'(TIMEOUT - 1) : '0;
  localparam logic [c_sel_bits:0]   c_sel_limit = (c_sel_bits + 1)'(NUM_SLAVES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                  state_q;
  logic                    cmd_ready_q;
  logic [NUM_SLAVES-1:0]   psel_q;
  logic                    penable_q;
  logic [ADDRWIDTH-1:0]    paddr_q;
  logic                    pwrite_q;
  logic [DATAWIDTH-1:0]    pwdata_q;
  logic [c_strb_w-1:0]     pstrb_q;
  logic [2:0]              pprot_q;
  logic                    rsp_valid_q;
  logic [DATAWIDTH-1:0]    rsp_rdata_q;
  logic                    rsp_err_q;
  logic                    rsp_timeout_q;
  logic [c_wait_w-1:0]     wait_q;

  logic [c_sel_bits-1:0]   sel_idx_d;
  logic                    sel_ok_d;
  logic [NUM_SLAVES-1:0]   psel_d;

  assign sel_idx_d = bus.cmd_addr[ADDRWIDTH-1 -: c_sel_bits];
  assign sel_ok_d  = {1'b0, sel_idx_d} < c_sel_limit;
  assign psel_d    = {{(NUM_SLAVES-1){1'b0}}, 1'b1} << sel_idx_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_ready_q && bus.cmd_valid) begin
            cmd_ready_q <= 1'b0;
            if (sel_ok_d) begin
              state_q  <= ST_SETUP;
              psel_q   <= psel_d;
              paddr_q  <= bus.cmd_addr;
              pwrite_q <= bus.cmd_write;
              pwdata_q <= bus.cmd_wdata;
              pstrb_q  <= bus.cmd_write ? bus.cmd_strb : '0;
              pprot_q  <= bus.cmd_prot;
            end else begin
              // Unmapped slave index: answer directly, the APB bus stays idle.
              state_q       <= ST_RESP;
              rsp_valid_q   <= 1'b1;
              rsp_err_q     <= 1'b1;
              rsp_timeout_q <= 1'b0;
              rsp_rdata_q   <= '0;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        ST_SETUP: begin
          penable_q <= 1'b1;
          wait_q    <= '0;
          state_q   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (bus.pready) begin
            state_q       <= ST_RESP;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= bus.pslverr;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= (!pwrite_q && !bus.pslverr) ? bus.prdata : '0;
          end else if ((TIMEOUT != 0) && (wait_q == c_wait_last)) begin
            state_q       <= ST_RESP;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end

        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.pprot       = pprot_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_apb4_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb4_requester
// Brief    : Self-checking bench for apb4_requester (3 slaves, TIMEOUT=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb4_requester;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NS = 3;
  localparam int TO = 16;
  localparam int SW = DW / 8;
  localparam int SB = $clog2(NS);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb4_requester_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .NUM_SLAVES(NS)) bus ();

  apb4_requester #(
    .ADDRWIDTH (AW),
    .DATAWIDTH (DW),
    .NUM_SLAVES(NS),
    .TIMEOUT   (TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k counts edges after acceptance: values observed here are those present at edge N+k.
  task automatic do_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [SW-1:0] st, input logic [2:0] pr, input int waits,
                        input logic [DW-1:0] rd, input bit err, input int rdly, input int abort_k);
    int idx, done_k;
    bit dec_err, tmo, exp_err;
    logic [NS-1:0] exp_sel;
    logic [DW-1:0] exp_rdata;
    logic [SW-1:0] exp_strb;
    logic [47:0]   exp_bus;

    idx       = int'(addr >> (AW - SB));
    dec_err   = (idx >= NS);
    tmo       = !dec_err && (waits >= TO);
    done_k    = dec_err ? 1 : (tmo ? 2 + TO : 3 + waits);
    exp_sel   = '0;
    if (!dec_err) exp_sel[idx] = 1'b1;
    exp_err   = dec_err || tmo || err;
    exp_rdata = (!wr && !exp_err) ? rd : '0;
    exp_strb  = wr ? st : '0;
    exp_bus   = {addr, wr, wd, exp_strb, pr};

    check("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    bus.cmd_strb  = st;
    bus.cmd_prot  = pr;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = AW'($urandom);
    bus.cmd_wdata = $urandom;
    bus.cmd_strb  = SW'($urandom);
    bus.cmd_prot  = 3'($urandom);

    for (int k = 1; k <= done_k; k++) begin
      if (k < done_k) begin
        check("psel", bus.psel, exp_sel);
        check("penable", bus.penable, (k >= 2));
        check("rsp_valid_busy", bus.rsp_valid, 0);
        check("cmd_ready_busy", bus.cmd_ready, 0);
        check("apb_fields", {bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb, bus.pprot}, exp_bus);
        if (abort_k != 0 && k == abort_k) begin
          rst = 1'b0;
          bus.pready = 1'b0;
          tick();
          check("rst_psel", bus.psel, 0);
          check("rst_penable", bus.penable, 0);
          check("rst_rsp_valid", bus.rsp_valid, 0);
          check("rst_cmd_ready", bus.cmd_ready, 0);
          rst = 1'b1;
          tick();
          check("post_rst_cmd_ready", bus.cmd_ready, 1);
          return;
        end
        bus.pready  = (k >= 2) ? (k == 2 + waits) : 1'($urandom);
        bus.prdata  = (bus.pready && k >= 2) ? rd : $urandom;
        bus.pslverr = (bus.pready && k >= 2) ? err : 1'($urandom);
        tick();
      end else begin
        check("rsp_valid", bus.rsp_valid, 1);
        check("idle_apb", {bus.psel, bus.penable, bus.pstrb}, 0);
        check("rsp_err", bus.rsp_err, exp_err);
        check("rsp_timeout", bus.rsp_timeout, tmo);
        check("rsp_rdata", bus.rsp_rdata, exp_rdata);
      end
    end

    for (int d = 0; d < rdly; d++) begin
      bus.rsp_ready = 1'b0;
      bus.cmd_valid = 1'($urandom);
      bus.pready    = 1'($urandom);
      bus.prdata    = $urandom;
      bus.pslverr   = 1'($urandom);
      tick();
      check("rsp_hold", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata},
            {1'b1, exp_err, tmo, exp_rdata});
      check("cmd_ready_resp", bus.cmd_ready, 0);
      check("psel_resp", bus.psel, 0);
    end
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b0;
    tick();
    bus.rsp_ready = 1'b0;
    check("rsp_done", bus.rsp_valid, 0);
    check("cmd_ready_back", bus.cmd_ready, 1);
  endtask

  initial begin
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.cmd_prot  = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    repeat (3) tick();
    check("reset_apb", {bus.psel, bus.penable, bus.paddr, bus.pwdata, bus.pstrb}, 0);
    check("reset_handshake", {bus.cmd_ready, bus.rsp_valid}, 0);
    rst = 1'b1;
    tick();
    check("cmd_ready_after_reset", bus.cmd_ready, 1);

    do_txn(1'b1, 8'h42, 32'hDEADBEEF, 4'hF, 3'd0, 0,  32'h0,        1'b0, 0, 0);
    do_txn(1'b0, 8'h80, 32'hCAFEF00D, 4'hA, 3'd2, 3,  32'h12345678, 1'b0, 1, 0);
    do_txn(1'b0, 8'h10, 32'h0,        4'h0, 3'd1, 1,  32'hA5A5A5A5, 1'b1, 0, 0);
    do_txn(1'b1, 8'h44, 32'h11223344, 4'h3, 3'd5, 30, 32'h0,        1'b0, 2, 0);
    do_txn(1'b0, 8'h7F, 32'h0,        4'h0, 3'd0, 15, 32'h0BADF00D, 1'b0, 0, 0);
    do_txn(1'b1, 8'hC0, 32'h55AA55AA, 4'hF, 3'd7, 0,  32'h0,        1'b0, 5, 0);
    do_txn(1'b0, 8'h40, 32'h0,        4'h0, 3'd3, 10, 32'h99999999, 1'b0, 0, 4);
    do_txn(1'b1, 8'h84, 32'h01020304, 4'h5, 3'd4, 0,  32'h0,        1'b0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      int w;
      w = ($urandom_range(0, 4) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 3));
      do_txn(1'($urandom), AW'($urandom), $urandom, SW'($urandom), 3'($urandom), w,
             $urandom, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
